// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared frame types and defaults for the i2s transmit path
package i2s_pkg;

    localparam int FRAME_W    = 32;
    localparam int CH_W       = 16;
    localparam int LRCK_RATIO = 256;
    localparam int SCK_RATIO  = 4;

    // Left channel occupies the upper half so it is shifted out first.
    typedef struct packed {
        logic [CH_W-1:0] left;
        logic [CH_W-1:0] right;
    } frame_t;

endpackage

// File: rtl/i2s_sample_fifo_if.sv
// rtl/i2s_sample_fifo_if.sv - producer write stream and transmitter request/frame bus
interface i2s_sample_fifo_if;

    i2s_pkg::frame_t wr_data;
    logic            wr_valid;
    logic            wr_ready;
    logic            sample_req;
    i2s_pkg::frame_t sound;

    modport master (
        output wr_data,
        output wr_valid,
        output sample_req,
        input  wr_ready,
        input  sound
    );

    modport slave (
        input  wr_data,
        input  wr_valid,
        input  sample_req,
        output wr_ready,
        output sound
    );

endinterface

// File: rtl/sample_ram.sv
// rtl/sample_ram.sv - simple dual-port frame RAM with registered read data
module sample_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // No reset on contents or read register so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/i2s_sample_fifo.sv
// rtl/i2s_sample_fifo.sv - frame FIFO feeding the i2s transmitter with underrun and mute handling
module i2s_sample_fifo
    import i2s_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int LOW_WATER     = 64,
    parameter int UNDERRUN_HOLD = 0
) (
    input  logic               clkin,
    input  logic               resetn,
    i2s_sample_fifo_if.slave   bus,
    input  logic               mute,
    output logic [ADDR_W:0]    level,
    output logic               low_water,
    output logic               underrun,
    output logic [15:0]        underrun_cnt,
    input  logic               clr_underrun
);

    localparam int             DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LOW_LEVEL  = (ADDR_W+1)'(LOW_WATER);
    localparam bit             HOLD       = (UNDERRUN_HOLD != 0);

    logic [1:0]        rst_sync;
    logic              rst_n;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push;
    logic              pop;
    logic              dry;
    logic              s1_req;
    logic              s1_pop;
    logic              s1_mute;
    logic [FRAME_W-1:0] ram_rdata;
    frame_t            sound_r;

    // Assert immediately, release two edges after resetn rises.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    assign bus.wr_ready = (level != FULL_LEVEL);
    assign push         = bus.wr_valid & bus.wr_ready;
    assign pop          = bus.sample_req & (level != '0);
    assign dry          = bus.sample_req & (level == '0);
    assign low_water    = (level < LOW_LEVEL);
    assign bus.sound    = sound_r;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    sample_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (FRAME_W)
    ) u_ram (
        .clk     (clkin),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (bus.wr_data),
        .rd_en   (pop),
        .rd_addr (rd_ptr),
        .rd_data (ram_rdata)
    );

    // The RAM registers rd_ptr in the request cycle; its data is consumed one cycle later.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            s1_req  <= 1'b0;
            s1_pop  <= 1'b0;
            s1_mute <= 1'b0;
            sound_r <= '0;
        end else begin
            s1_req  <= bus.sample_req;
            s1_pop  <= pop;
            s1_mute <= mute;
            if (s1_req) begin
                if (s1_mute) begin
                    sound_r <= '0;
                end else if (s1_pop) begin
                    sound_r <= ram_rdata;
                end else if (!HOLD) begin
                    sound_r <= '0;
                end
            end
        end
    end

    // An underrun in the same cycle as a clear wins and restarts the count at one.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else if (dry) begin
            underrun <= 1'b1;
            if (clr_underrun) begin
                underrun_cnt <= 16'd1;
            end else if (underrun_cnt != 16'hFFFF) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end else if (clr_underrun) begin
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// tb/tb_i2s_sample_fifo.sv - randomized bench for i2s_sample_fifo against a queue reference model
module tb_i2s_sample_fifo;
    import i2s_pkg::*;

    logic        clkin = 1'b0;
    logic        resetn = 1'b0;
    logic        mute = 1'b0;
    logic        clr_underrun = 1'b0;
    logic [8:0]  level0, level1;
    logic        low_water0, low_water1;
    logic        underrun0, underrun1;
    logic [15:0] cnt0, cnt1;

    always #5 clkin = ~clkin;

    i2s_sample_fifo_if bus0();
    i2s_sample_fifo_if bus1();

    i2s_sample_fifo #(.ADDR_W(8), .LOW_WATER(64), .UNDERRUN_HOLD(0)) dut0 (
        .clkin(clkin), .resetn(resetn), .bus(bus0), .mute(mute),
        .level(level0), .low_water(low_water0), .underrun(underrun0),
        .underrun_cnt(cnt0), .clr_underrun(clr_underrun)
    );

    i2s_sample_fifo #(.ADDR_W(8), .LOW_WATER(64), .UNDERRUN_HOLD(1)) dut1 (
        .clkin(clkin), .resetn(resetn), .bus(bus1), .mute(mute),
        .level(level1), .low_water(low_water1), .underrun(underrun1),
        .underrun_cnt(cnt1), .clr_underrun(clr_underrun)
    );

    logic [31:0] q[$];
    logic [31:0] m_sound[2];
    logic [31:0] m_last[2];
    logic [31:0] pend[2];
    bit          pend_v;
    bit          m_urun;
    int          m_cnt;
    int          n_pass = 0;
    int          n_chk = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("sound_h0", 32'(bus0.sound), m_sound[0]);
        check("sound_h1", 32'(bus1.sound), m_sound[1]);
        check("level", 32'(level0), 32'(q.size()));
        check("level_h1", 32'(level1), 32'(q.size()));
        check("wr_ready", 32'(bus0.wr_ready), 32'(q.size() != 256));
        check("low_water", 32'(low_water0), 32'(q.size() < 64));
        check("underrun", 32'(underrun0), 32'(m_urun));
        check("underrun_cnt", 32'(cnt0), 32'(m_cnt));
        check("underrun_cnt_h1", 32'(cnt1), 32'(m_cnt));
    endtask

    task automatic model_reset();
        q.delete();
        for (int h = 0; h < 2; h++) begin
            m_sound[h] = '0;
            m_last[h]  = '0;
            pend[h]    = '0;
        end
        pend_v = 1'b0;
        m_urun = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic drive(input bit wv, input logic [31:0] wd, input bit req, input bit mu, input bit clr);
        bus0.wr_valid   = wv;
        bus1.wr_valid   = wv;
        bus0.wr_data    = wd;
        bus1.wr_data    = wd;
        bus0.sample_req = req;
        bus1.sample_req = req;
        mute            = mu;
        clr_underrun    = clr;
    endtask

    // Called at a falling edge: check, drive, advance the model across the next rising edge.
    task automatic step(input bit wv, input logic [31:0] wd, input bit req, input bit mu,
                        input bit clr, input bit chk);
        bit push;
        bit pop;
        if (chk) check_all();
        drive(wv, wd, req, mu, clr);
        push = wv && (q.size() != 256);
        pop  = req && (q.size() != 0);
        if (pend_v) begin
            m_sound[0] = pend[0];
            m_sound[1] = pend[1];
        end
        pend_v = req;
        if (req) begin
            for (int h = 0; h < 2; h++) begin
                if (mu) pend[h] = '0;
                else if (pop) pend[h] = q[0];
                else pend[h] = (h == 1) ? m_last[h] : 32'h0;
                m_last[h] = pend[h];
            end
        end
        if (pop) void'(q.pop_front());
        if (push) q.push_back(wd);
        if (req && !pop) begin
            m_urun = 1'b1;
            m_cnt  = clr ? 1 : ((m_cnt == 65535) ? 65535 : m_cnt + 1);
        end else if (clr) begin
            m_urun = 1'b0;
            m_cnt  = 0;
        end
        @(posedge clkin);
        @(negedge clkin);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        resetn = 1'b0;
        model_reset();
        repeat (2) @(negedge clkin);
        resetn = 1'b1;
        idle(3);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        model_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clkin);
        resetn = 1'b1;
        idle(3);

        // Request on empty, then clear.
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1);

        // Two frames, back-to-back requests.
        step(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Fill past full, push+pop while full, drain across the pointer wrap.
        for (int i = 0; i < 257; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 260; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Low watermark boundary at 64/63.
        for (int i = 0; i < 64; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1);
        for (int i = 0; i < 63; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Hold-on-underrun and mute.
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h00010002, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);
        step(1'b1, 32'h7FFF8000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(3);

        // Counter saturation, then clear coinciding with an underrun.
        for (int i = 0; i < 66000; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Randomized traffic: producer-heavy then consumer-heavy.
        for (int i = 0; i < 3000; i++) begin
            bit wv  = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            bit req = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(wv, $urandom, req, $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0, 1'b1);
        end
        idle(3);

        // Reset with 100 frames buffered and a request in flight.
        do_reset();
        for (int i = 0; i < 100; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1 resetn = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clkin);
        @(negedge clkin);
        resetn = 1'b1;
        idle(3);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);
        step(1'b1, 32'h55AA33CC, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
